// File: rtl/data_store_pkg.sv
// Shared FSM state encoding and capture-mode constants for the sample store.
// Latency: n/a; backpressure: n/a (definitions only).
package data_store_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int WRAP_STOP     = 0;
  localparam int WRAP_CIRCULAR = 1;

endpackage

// File: rtl/data_store_stats_if.sv
// Capture, read-back and status bundle between a sample source/reader and the store.
// Latency: n/a; backpressure: none, capture and reads are always accepted.
interface data_store_stats_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic              data_start;
  logic [DATA_W-1:0] data;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CW-1:0]     count;
  logic              full;
  logic              overflow;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic              done;

  modport master (
    output data_start, data, rd_en, rd_addr,
    input  rd_data, rd_valid, count, full, overflow, min_val, max_val, done
  );

  modport slave (
    input  data_start, data, rd_en, rd_addr,
    output rd_data, rd_valid, count, full, overflow, min_val, max_val, done
  );
endinterface

// File: rtl/ds_ram.sv
// DEPTH x DATA_W sample RAM, one write port, one registered read-before-write read port.
// Latency: read data one cycle after re; backpressure: none.
module ds_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  input  logic              rzero,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array is gated by the caller's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rzero ? '0 : mem[raddr];
  end

endmodule

// File: rtl/data_store_stats.sv
// Captures a burst of samples into a stop-when-full or circular buffer with running min/max.
// Latency: reads return one cycle after rd_en; backpressure: none, samples past a stop-mode fill are dropped.
module data_store_stats
  import data_store_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int WRAP   = WRAP_STOP
) (
  input logic               clk,
  input logic               rst_n,
  data_store_stats_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit STOP_WHEN_FULL = (WRAP != WRAP_CIRCULAR);

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr, oldest, wr_addr, rd_phys;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] min_q, max_q, rd_data;
  logic              ovf_q, rd_valid_q;
  logic              wr_en, start, done, rd_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.data_start) state_d = CAPTURE;
      CAPTURE: begin
        if (!bus.data_start)
          state_d = DONE;
        else if (STOP_WHEN_FULL && count_q == FULL_CNT - 1'b1)
          state_d = DONE;
      end
      DONE:    if (!bus.data_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE: begin
        wr_en = bus.data_start;
        start = bus.data_start;
      end
      CAPTURE: wr_en = bus.data_start;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // A fresh capture always lands at physical 0, whatever the old pointers were.
  assign wr_addr = start ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      oldest  <= '0;
      count_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      wr_ptr  <= AW'(1);
      oldest  <= '0;
      count_q <= CW'(1);
      min_q   <= bus.data;
      max_q   <= bus.data;
      ovf_q   <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count_q == FULL_CNT) begin
        oldest <= oldest + 1'b1;
        ovf_q  <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
      if (bus.data < min_q) min_q <= bus.data;
      if (bus.data > max_q) max_q <= bus.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= bus.rd_en;
  end

  assign rd_phys = oldest + bus.rd_addr;
  assign rd_oob  = CW'(bus.rd_addr) >= count_q;

  ds_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (bus.data),
    .re    (bus.rd_en),
    .raddr (rd_phys),
    .rzero (rd_oob),
    .rdata (rd_data)
  );

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.full     = (count_q == FULL_CNT);
  assign bus.overflow = ovf_q;
  assign bus.min_val  = min_q;
  assign bus.max_val  = max_q;
  assign bus.done     = done;

endmodule

// File: tb/tb_data_store_stats.sv
// Drives a stop-mode (DEPTH=16) and a circular (DEPTH=4) store with shared stimulus,
// comparing each against a sample-list reference model through read scoreboards.
module tb_data_store_stats;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ds, re;
  logic [15:0] d;
  logic [3:0]  ra;

  always #5 clk = ~clk;

  data_store_stats_if #(.DATA_W(16), .DEPTH(16)) bus_a ();
  data_store_stats_if #(.DATA_W(16), .DEPTH(4))  bus_b ();

  assign bus_a.data_start = ds;
  assign bus_a.data       = d;
  assign bus_a.rd_en      = re;
  assign bus_a.rd_addr    = ra;
  assign bus_b.data_start = ds;
  assign bus_b.data       = d;
  assign bus_b.rd_en      = re;
  assign bus_b.rd_addr    = ra[1:0];

  data_store_stats #(.DATA_W(16), .DEPTH(16), .WRAP(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  data_store_stats #(.DATA_W(16), .DEPTH(4),  .WRAP(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per instance, the held samples as an oldest-first list.
  int          dep [2] = '{16, 4};
  bit          wrp [2] = '{1'b0, 1'b1};
  logic [15:0] hold [2][16];
  int          hcnt [2];
  int          ph [2];          // 0 idle, 1 capturing, 2 done
  logic [15:0] mn [2], mx [2], last_rd [2];
  bit          ovf [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hcnt[k] = 0; ph[k] = 0; mn[k] = '0; mx[k] = '0; ovf[k] = 1'b0; last_rd[k] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_edge(input int k, input bit s, input logic [15:0] v);
    case (ph[k])
      0: if (s) begin
        hcnt[k] = 1; hold[k][0] = v; mn[k] = v; mx[k] = v; ovf[k] = 1'b0; ph[k] = 1;
      end
      1: if (!s) ph[k] = 2;
         else begin
           if (hcnt[k] < dep[k]) begin
             hold[k][hcnt[k]] = v;
             hcnt[k]++;
           end else begin
             for (int i = 0; i < dep[k] - 1; i++) hold[k][i] = hold[k][i+1];
             hold[k][dep[k]-1] = v;
             ovf[k] = 1'b1;
           end
           if (v < mn[k]) mn[k] = v;
           if (v > mx[k]) mx[k] = v;
           if (!wrp[k] && hcnt[k] == dep[k]) ph[k] = 2;
         end
      default: if (!s) ph[k] = 0;
    endcase
  endtask

  task automatic cycle(input bit s, input logic [15:0] v, input bit r, input logic [3:0] a);
    @(negedge clk);
    ds = s; d = v; re = r; ra = a;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int ak;
      logic [15:0] e;
      ak = (k == 0) ? int'(a) : int'(a[1:0]);
      e = (ak < hcnt[k]) ? hold[k][ak] : 16'd0;
      if (r) begin
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
      model_edge(k, s, v);
    end
  endtask

  task automatic chk_reset_outputs(input string t);
    chk({t, "_a_count"},    32'(bus_a.count),    0);
    chk({t, "_a_min"},      32'(bus_a.min_val),  0);
    chk({t, "_a_max"},      32'(bus_a.max_val),  0);
    chk({t, "_a_full"},     32'(bus_a.full),     0);
    chk({t, "_a_done"},     32'(bus_a.done),     0);
    chk({t, "_a_rd_valid"}, 32'(bus_a.rd_valid), 0);
    chk({t, "_a_rd_data"},  32'(bus_a.rd_data),  0);
    chk({t, "_b_count"},    32'(bus_b.count),    0);
    chk({t, "_b_overflow"}, 32'(bus_b.overflow), 0);
    chk({t, "_b_max"},      32'(bus_b.max_val),  0);
  endtask

  task automatic mon_cmp(input string t, input int k,
                         input logic [31:0] cnt, input logic [31:0] fl, input logic [31:0] ov,
                         input logic [31:0] dn, input logic [31:0] mnv, input logic [31:0] mxv,
                         input logic [31:0] rv, input logic [31:0] rd);
    bit pend;
    pend = (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    if (pend) begin
      if (k == 0) last_rd[k] = exp_q0.pop_front();
      else        last_rd[k] = exp_q1.pop_front();
    end
    chk({t, "_rd_valid"}, rv,  32'(pend));
    chk({t, "_rd_data"},  rd,  32'(last_rd[k]));
    chk({t, "_count"},    cnt, 32'(hcnt[k]));
    chk({t, "_full"},     fl,  32'(hcnt[k] == dep[k]));
    chk({t, "_overflow"}, ov,  32'(ovf[k]));
    chk({t, "_done"},     dn,  32'(ph[k] == 2));
    chk({t, "_min"},      mnv, 32'(mn[k]));
    chk({t, "_max"},      mxv, 32'(mx[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_cmp("a", 0, 32'(bus_a.count), 32'(bus_a.full), 32'(bus_a.overflow), 32'(bus_a.done),
              32'(bus_a.min_val), 32'(bus_a.max_val), 32'(bus_a.rd_valid), 32'(bus_a.rd_data));
      mon_cmp("b", 1, 32'(bus_b.count), 32'(bus_b.full), 32'(bus_b.overflow), 32'(bus_b.done),
              32'(bus_b.min_val), 32'(bus_b.max_val), 32'(bus_b.rd_valid), 32'(bus_b.rd_data));
    end
  end

  initial begin
    logic [15:0] wrap_rd [4];
    wrap_rd[0] = 16'd1; wrap_rd[1] = 16'd2; wrap_rd[2] = 16'd2; wrap_rd[3] = 16'd1;
    rst_n = 1'b0; ds = 1'b0; d = '0; re = 1'b0; ra = '0;
    model_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #1 chk_reset_outputs("por");
    @(negedge clk); rst_n = 1'b1;

    // Ten descending samples, then reads including an out-of-range index.
    for (int i = 0; i < 10; i++) cycle(1, 16'(10 - i), 0, 0);
    cycle(0, 0, 0, 0);
    #1;
    chk("s1_count", 32'(bus_a.count), 10);
    chk("s1_min", 32'(bus_a.min_val), 1);
    chk("s1_max", 32'(bus_a.max_val), 10);
    chk("s1_done", 32'(bus_a.done), 1);
    cycle(0, 0, 1, 0);  #1 chk("s1_rd0", 32'(bus_a.rd_data), 10);
    cycle(0, 0, 1, 9);  #1 chk("s1_rd9", 32'(bus_a.rd_data), 1);
    cycle(0, 0, 1, 12);
    #1;
    chk("s1_rd12", 32'(bus_a.rd_data), 0);
    chk("s1_rd12_valid", 32'(bus_a.rd_valid), 1);

    // Eighteen samples with start held: stop-mode fills and ignores the rest.
    for (int i = 1; i <= 18; i++) begin
      cycle(1, 16'(i), 0, 0);
      #1;
      if (i == 15) chk("s2_done_before_full", 32'(bus_a.done), 0);
      if (i == 16) chk("s2_done_at_full", 32'(bus_a.done), 1);
    end
    chk("s2_count", 32'(bus_a.count), 16);
    chk("s2_full", 32'(bus_a.full), 1);
    chk("s2_max", 32'(bus_a.max_val), 16);
    cycle(0, 0, 1, 15); #1 chk("s2_rd15", 32'(bus_a.rd_data), 16);

    // Circular overwrite on the 4-entry store.
    cycle(0, 0, 0, 0);
    cycle(1, 13, 0, 0); cycle(1, 12, 0, 0); cycle(1, 1, 0, 0);
    cycle(1, 2, 0, 0);  cycle(1, 2, 0, 0);  cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    #1;
    chk("s3_count", 32'(bus_b.count), 4);
    chk("s3_overflow", 32'(bus_b.overflow), 1);
    chk("s3_min", 32'(bus_b.min_val), 1);
    chk("s3_max", 32'(bus_b.max_val), 13);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 4'(i));
      #1 chk("s3_rd", 32'(bus_b.rd_data), 32'(wrap_rd[i]));
    end

    // Reads colliding with writes return the pre-write contents.
    cycle(1, 100, 1, 0); #1 chk("s4_rw_start", 32'(bus_a.rd_data), 13);
    cycle(1, 101, 0, 0);
    cycle(1, 102, 1, 2); #1 chk("s4_rw_unheld", 32'(bus_a.rd_data), 0);
    cycle(1, 103, 0, 0);
    cycle(1, 104, 1, 0); #1 chk("s4_rw_overwrite", 32'(bus_b.rd_data), 100);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Reset in the middle of a capture, then a short fresh capture.
    for (int i = 0; i < 5; i++) cycle(1, 16'(50 + i), 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0; ds = 1'b0; re = 1'b0;
    model_reset();
    #1 chk_reset_outputs("mid");
    @(negedge clk); rst_n = 1'b1;
    cycle(1, 7, 0, 0); cycle(1, 8, 0, 0); cycle(1, 9, 0, 0);
    cycle(0, 0, 0, 0);
    #1;
    chk("s5_count", 32'(bus_a.count), 3);
    chk("s5_min", 32'(bus_a.min_val), 7);
    chk("s5_max", 32'(bus_a.max_val), 9);
    chk("s5_b_count", 32'(bus_b.count), 3);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit s, r;
      logic [15:0] v;
      s = ($urandom_range(0, 9) < 8);
      r = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      cycle(s, v, r, 4'($urandom_range(0, 15)));
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
